nn_feature_loader: RTL and testbench
====================================

# nn_feature_loader

Upstream input stage for the network datapath. It accepts a serial stream of 16-bit feature words with a valid/ready handshake and assembles FEATURES consecutive words into one parallel feature vector. It presents the vector with a valid/ready handshake to the first `nn_Linear` layer's `data_in` array. A fill buffer and an output register form a double buffer, so a new frame can be loaded while the previous vector waits to be consumed. Frame-boundary errors are detected and recovered from.

## Interface
- `FEATURES`, 11, number of words per frame and width of the output array (≥2)
- `DATA_W`, 16, feature word width; passed through unchanged, no arithmetic

- `clk_in`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_data`  in  DATA_W  incoming feature word
- `s_valid`  in  1  `s_data`/`s_last` valid
- `s_last`  in  1  marks final word of a frame
- `s_ready`  out  1  loader accepts a word this cycle
- `vec_data`  out  DATA_W × [FEATURES]  assembled vector; element 0 = first word of frame
- `vec_valid`  out  1  `vec_data` holds a complete frame
- `vec_ready`  in  1  downstream consumes `vec_data`
- `frame_err`  out  1  one-cycle pulse on a malformed frame
- `frame_cnt`  out  16  count of vectors handed off (`vec_valid && vec_ready`), wraps at 2^16

## Operation
- Word accepted when `s_valid && s_ready` at a rising edge. Fill index `idx` runs 0..FEATURES-1, and the word is written to `fill[idx]`.
- States:
  - **FILL**: `s_ready = 1`.
    - Accepted word with `idx < FEATURES-1` and `!s_last`: store it, then `idx++`.
    - Accepted word with `idx < FEATURES-1` and `s_last` (short frame): discard the partial frame, set `idx = 0`, pulse `frame_err`, stay in FILL.
    - Accepted word with `idx == FEATURES-1` and `!s_last` (long frame): discard, `idx = 0`, pulse `frame_err`, go to SYNC.
    - Accepted word with `idx == FEATURES-1` and `s_last`: frame complete, `idx = 0`.
      - If the output slot is free (`!vec_valid || vec_ready` at the same edge), copy fill plus the current word into `vec_data`, set `vec_valid = 1`, and stay in FILL.
      - Otherwise go to FULL.
  - **FULL**: `s_ready = 0`. At the first edge where the output slot is free, copy fill into `vec_data`, set `vec_valid = 1`, and go to FILL.
  - **SYNC**: `s_ready = 1`. Accepted words are dropped. An accepted word with `s_last` returns the block to FILL with `idx = 0`. No further `frame_err` is raised in SYNC.
- `vec_valid` rules:
  - Cleared at an edge with `vec_valid && vec_ready`, unless a new vector is loaded at the same edge; a new load takes priority.
  - `vec_data` is stable while `vec_valid && !vec_ready`.
- `frame_cnt` increments on every `vec_valid && vec_ready` edge.
- `s_ready` is a decode of the registered state only. It has no combinational path from `vec_ready`.

## Timing
- Reset values: state = FILL, `idx = 0`, `s_ready = 1`, `vec_valid = 0`, `vec_data = 0`, `frame_err = 0`, `frame_cnt = 0`. Fill buffer contents are don't-care.
- Latency: the last word is accepted at edge k → `vec_valid` is high after edge k (visible in cycle k+1) when the slot is free.
- Throughput:
  - With `vec_ready` tied high, one frame per FEATURES cycles and no stall cycles.
  - With the slot busy, `s_ready` stays low from the edge after the last word until the edge at which the transfer happens.
- `frame_err` is high for exactly the cycle after the offending edge.
- Reset asserted mid-frame or mid-FULL: everything returns to reset values immediately (asynchronous assertion). The partial or pending frame is lost and no `frame_err` is raised.
- Reset deassertion is synchronized externally; the block needs no internal synchronizer.

## Structure
- Shared package `nn_pkg`: `DATA_W` default, `typedef logic [DATA_W-1:0] nn_word_t`, and the state enum `loader_state_e {FILL, FULL, SYNC}`. The package is shared with `nn_Linear` and `nn_ReLU` vector types.
- Single module, with no sub-module. The index counter, state register, fill array and output array all live in `nn_feature_loader`.

## Test plan
All scenarios use FEATURES = 11.
- **Basic frame:** reset, then send words 0x0001..0x000B with `s_last` on the 11th and `vec_ready = 1`. Required: `vec_valid` is high one cycle after the last word, `vec_data[0] = 0x0001`, `vec_data[10] = 0x000B`, and `frame_cnt = 1`.
- **Back-pressure:** hold `vec_ready = 0` and send two full frames. Required: frame A is in `vec_data`, `s_ready` drops after frame B's last word, and `vec_data` stays at A. Then raise `vec_ready` for 1 cycle. Required: `vec_data` becomes B with `vec_valid` still high, `s_ready` returns to 1, and `frame_cnt = 1`.
- **Short frame:** send 5 words with `s_last` on the 5th. Required: a one-cycle `frame_err` pulse, no `vec_valid`, and the next 11-word frame is assembled correctly.
- **Long frame:** send 11 words with no `s_last`. Required: `frame_err` pulses and the block enters SYNC. Then send 3 words, the third with `s_last`. Required: all three are dropped, no `vec_valid` appears, and the next valid frame is output correctly.
- **Reset mid-frame:** assert `rst_n = 0` after 6 words. Required: `vec_valid = 0`, `s_ready = 1`, `frame_cnt = 0`, and the next full frame starts at `vec_data[0]`.
- **Streaming:** `s_valid = 1` and `vec_ready = 1` continuously for 100 frames. Required: `s_ready` never drops, `vec_valid` goes high every 11 cycles, and `frame_cnt = 100`.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the nn datapath: word width, word type and loader state encoding.
package nn_pkg;

  localparam int NN_DATA_W = 16;

  typedef logic [NN_DATA_W-1:0] nn_word_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    SYNC = 2'd2
  } loader_state_e;

endpackage

// File: rtl/nn_feature_loader.sv
// Serial-to-parallel feature loader. The fill buffer and output register form a
// double buffer: the next frame fills while the current vector waits downstream.
// Frames shorter or longer than FEATURES words raise frame_err and are discarded.
module nn_feature_loader
  import nn_pkg::*;
#(
  parameter int FEATURES = 11,
  parameter int DATA_W   = NN_DATA_W
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                s_data,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [FEATURES-1:0][DATA_W-1:0]  vec_data,
  output logic                             vec_valid,
  input  logic                             vec_ready,
  output logic                             frame_err,
  output logic [15:0]                      frame_cnt
);

  localparam int IDX_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

  typedef logic [FEATURES-1:0][DATA_W-1:0] vec_t;

  loader_state_e    state;
  logic [IDX_W-1:0] idx;
  vec_t             fill;
  vec_t             load_vec;
  logic             accept;
  logic             slot_free;
  logic             at_last;
  logic             load;

  // Ready is a pure decode of the registered state; no path from vec_ready.
  assign s_ready = (state != FULL);

  // Handshake qualifiers and the output-register load condition.
  always_comb begin
    accept    = s_valid && s_ready;
    slot_free = !vec_valid || vec_ready;
    at_last   = (idx == LAST_IDX);
    load      = ((state == FILL) && accept && at_last && s_last && slot_free) ||
                ((state == FULL) && slot_free);
  end

  // Vector to load: in FILL the final word bypasses the fill buffer;
  // in FULL it was already written there on the completing edge.
  always_comb begin
    load_vec = fill;
    if (state == FILL) load_vec[FEATURES-1] = s_data;
  end

  // Fill buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_in) begin
    if ((state == FILL) && accept) fill[idx] <= s_data;
  end

  // Frame FSM: tracks fill position, detects short/long frames, resyncs on s_last.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (!at_last) begin
              if (s_last) begin
                idx       <= '0;
                frame_err <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              idx <= '0;
              if (!s_last) begin
                frame_err <= 1'b1;
                state     <= SYNC;
              end else if (!slot_free) begin
                state <= FULL;
              end
            end
          end
        end
        FULL: begin
          if (slot_free) state <= FILL;
        end
        SYNC: begin
          if (accept && s_last) begin
            state <= FILL;
            idx   <= '0;
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
        end
      endcase
    end
  end

  // Output register and handoff counter; a new load wins over a clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vec_data  <= '0;
      vec_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (load) begin
        vec_data  <= load_vec;
        vec_valid <= 1'b1;
      end else if (vec_valid && vec_ready) begin
        vec_valid <= 1'b0;
      end
      if (vec_valid && vec_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_nn_feature_loader.sv
// Scoreboard bench for nn_feature_loader with FEATURES = 11.
module tb_nn_feature_loader;
  import nn_pkg::*;

  localparam int F = 11;
  localparam int W = NN_DATA_W;
  typedef logic [F-1:0][W-1:0] vec_t;

  logic                clk_in = 1'b0;
  logic                rst_n;
  logic [W-1:0]        s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [F-1:0][W-1:0] vec_data;
  logic                vec_valid;
  logic                vec_ready;
  logic                frame_err;
  logic [15:0]         frame_cnt;

  nn_feature_loader #(.FEATURES(F), .DATA_W(W)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t exp_v;
  int   mdl_cnt = 0;
  int   err_seen = 0;
  int   vv_seen = 0;
  int   vv_stream = 0;
  int   rdy_drop = 0;
  int   gap_bad = 0;
  int   cyc = 0;
  int   last_vv = -1;
  bit   streaming = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Values present at the negedge are the ones seen at the following posedge.
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_n) begin
      mdl_cnt = 0;
    end else begin
      if (vec_valid && vec_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 256'(vec_data), 256'(0));
        end else begin
          exp_v = sb.pop_front();
          check("sb_vec", 256'(vec_data), 256'(exp_v));
        end
        mdl_cnt++;
      end
      if (frame_err) err_seen++;
      if (vec_valid) vv_seen++;
      if (streaming) begin
        if (!s_ready) rdy_drop++;
        if (vec_valid) begin
          vv_stream++;
          if (last_vv >= 0 && (cyc - last_vv) != F) gap_bad++;
          last_vv = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("send_timeout", 256'(1), 256'(0));
    step();
  endtask

  task automatic send_frame(input int base, input bit good);
    vec_t v;
    for (int i = 0; i < F; i++) v[i] = W'(base + i);
    if (good) sb.push_back(v);
    for (int i = 0; i < F; i++) send(W'(base + i), good && (i == F - 1));
  endtask

  task automatic drain();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    check("frame_cnt_model", 256'(frame_cnt), 256'(mdl_cnt));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    #2;
    check("rst_vec_valid", 256'(vec_valid), 256'(0));
    check("rst_s_ready",   256'(s_ready),   256'(1));
    check("rst_frame_cnt", 256'(frame_cnt), 256'(0));
    check("rst_frame_err", 256'(frame_err), 256'(0));
    check("rst_vec_data",  256'(vec_data),  256'(0));
    @(negedge clk_in);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int e0;
    int v0;
    rst_n     = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    vec_ready = 1'b0;
    step();
    do_reset();

    // Basic frame
    vec_ready = 1'b1;
    send_frame(1, 1'b1);
    check("basic_vv",    256'(vec_valid),    256'(1));
    check("basic_d0",    256'(vec_data[0]),  256'(16'h0001));
    check("basic_d10",   256'(vec_data[10]), 256'(16'h000B));
    drain();
    check("basic_cnt",   256'(frame_cnt),    256'(1));
    check("basic_vv_lo", 256'(vec_valid),    256'(0));

    // Back-pressure: A sits in the output, B fills behind it
    vec_ready = 1'b0;
    send_frame(16'h0100, 1'b1);
    send_frame(16'h0200, 1'b1);
    check("bp_s_ready_lo", 256'(s_ready),     256'(0));
    check("bp_hold_a",     256'(vec_data[0]), 256'(16'h0100));
    s_valid = 1'b0;
    step();
    step();
    check("bp_still_a",    256'(vec_data[5]), 256'(16'h0105));
    check("bp_s_ready_lo2",256'(s_ready),     256'(0));
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    check("bp_vv",      256'(vec_valid),    256'(1));
    check("bp_b0",      256'(vec_data[0]),  256'(16'h0200));
    check("bp_b10",     256'(vec_data[10]), 256'(16'h020A));
    check("bp_s_ready", 256'(s_ready),      256'(1));
    check("bp_cnt",     256'(frame_cnt),    256'(2));
    vec_ready = 1'b1;
    drain();
    check("bp_cnt2",    256'(frame_cnt),    256'(3));

    // Short frame
    for (int i = 0; i < 5; i++) send(W'(16'h0700 + i), i == 4);
    check("short_err",  256'(frame_err), 256'(1));
    check("short_vv",   256'(vec_valid), 256'(0));
    s_valid = 1'b0;
    step();
    check("short_err_lo", 256'(frame_err), 256'(0));
    send_frame(16'h0300, 1'b1);
    drain();
    check("short_cnt",  256'(frame_cnt), 256'(4));

    // Long frame, then three dropped words ending in s_last
    e0 = err_seen;
    v0 = vv_seen;
    send_frame(16'h0800, 1'b0);
    check("long_err",   256'(frame_err), 256'(1));
    for (int i = 0; i < 3; i++) send(W'(16'h0900 + i), i == 2);
    s_valid = 1'b0;
    step();
    check("long_err_once", 256'(err_seen - e0), 256'(1));
    check("long_no_vv",    256'(vv_seen - v0),  256'(0));
    send_frame(16'h0400, 1'b1);
    drain();
    check("long_cnt",   256'(frame_cnt), 256'(5));

    // Reset mid-frame
    for (int i = 0; i < 6; i++) send(W'(16'h0500 + i), 1'b0);
    do_reset();
    send_frame(16'h0600, 1'b1);
    check("rst_next_d0", 256'(vec_data[0]), 256'(16'h0600));
    drain();
    check("rst_next_cnt", 256'(frame_cnt), 256'(1));

    // Streaming 100 frames back to back
    do_reset();
    vec_ready = 1'b1;
    last_vv   = -1;
    streaming = 1'b1;
    for (int f = 0; f < 100; f++) send_frame((f * 37) & 16'hFFFF, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    streaming = 1'b0;
    check("stream_rdy_drop", 256'(rdy_drop),  256'(0));
    check("stream_vv_count", 256'(vv_stream), 256'(100));
    check("stream_gap",      256'(gap_bad),   256'(0));
    check("stream_cnt",      256'(frame_cnt), 256'(100));
    check("stream_cnt_model",256'(frame_cnt), 256'(mdl_cnt));
    check("sb_empty",        256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
